// File: rtl/pw_capture.sv
// Pulse-width capture: times the synchronized high phase of pulse_in in prescaled ticks
// and publishes a stable, saturating result word for a downstream PIO.
module pw_capture #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 50
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] pw_value,
    output logic             pw_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned      PW         = 16;
    localparam logic [PW-1:0]    DIV_LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] COUNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOW,
        ARMED,
        MEASURE
    } state_t;

    state_t           state, state_next;
    logic             sync1, sync, prev;
    logic             rise, fall, tick;
    logic [PW-1:0]    presc, presc_next;
    logic [WIDTH-1:0] count, count_next, count_inc;
    logic             publish;
    logic [WIDTH-1:0] pub_value;
    logic             pub_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= pulse_in;
            sync  <= sync1;
            prev  <= sync;
        end
    end

    assign rise      = sync & ~prev;
    assign fall      = ~sync & prev;
    assign tick      = (CLK_DIV == 1) || (presc == DIV_LAST);
    assign count_inc = count + {{(WIDTH-1){1'b0}}, tick};

    always_comb begin
        state_next = state;
        presc_next = presc;
        count_next = count;
        publish    = 1'b0;
        pub_value  = pw_value;
        pub_ovf    = overflow;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = WAIT_LOW;
                // Both synchronizer stages must be low, so a pulse that was already
                // high when the synchronizer was cleared (reset) is not mistaken for a new rise.
                WAIT_LOW: if (!sync1 && !sync) state_next = ARMED;
                ARMED: begin
                    if (rise) begin
                        presc_next = '0;
                        count_next = '0;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    presc_next = tick ? '0 : presc + PRESC_ONE;
                    count_next = count_inc;
                    if (count_inc == COUNT_MAX) begin
                        publish    = 1'b1;
                        pub_value  = COUNT_MAX;
                        pub_ovf    = 1'b1;
                        state_next = WAIT_LOW;
                    end else if (fall) begin
                        publish    = 1'b1;
                        pub_value  = count_inc;
                        pub_ovf    = 1'b0;
                        state_next = ARMED;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            presc    <= '0;
            count    <= '0;
            pw_value <= '0;
            overflow <= 1'b0;
            pw_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            presc    <= presc_next;
            count    <= count_next;
            pw_valid <= publish;
            busy     <= (state_next == MEASURE);
            if (publish) begin
                pw_value <= pub_value;
                overflow <= pub_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pw_capture.sv
// Directed bench for pw_capture: a CLK_DIV=50 instance for width/latency cases and a
// CLK_DIV=1 instance for saturation.
module tb_pw_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        p50 = 1'b0, p1 = 1'b0;
    logic [15:0] v50, v1;
    logic        val50, val1, ov50, ov1, b50, b1;

    int          sel = 0;
    logic [15:0] m_value;
    logic        m_valid, m_ovf, m_busy;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        int unsigned n;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    pw_capture #(.WIDTH(16), .CLK_DIV(50)) dut50 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pulse_in(p50),
        .pw_value(v50), .pw_valid(val50), .overflow(ov50), .busy(b50)
    );

    pw_capture #(.WIDTH(16), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pulse_in(p1),
        .pw_value(v1), .pw_valid(val1), .overflow(ov1), .busy(b1)
    );

    always_comb begin
        m_value = (sel != 0) ? v1 : v50;
        m_valid = (sel != 0) ? val1 : val50;
        m_ovf   = (sel != 0) ? ov1 : ov50;
        m_busy  = (sel != 0) ? b1 : b50;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pulse(input logic v);
        if (sel != 0) p1 = v;
        else p50 = v;
    endtask

    // Count strobes and busy over n cycles.
    task automatic watch(input int unsigned n, output int strobes, output int busy_cnt);
        strobes  = 0;
        busy_cnt = 0;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (m_valid) strobes++;
            if (m_busy) busy_cnt++;
        end
    endtask

    task automatic run_pulse(input int unsigned n, input logic [15:0] exp, input logic exp_ovf);
        int strobes;
        strobes = 0;
        tick_n(6);
        set_pulse(1'b1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (m_valid) strobes++;
            if (n >= 4 && i == n - 1) chk($sformatf("busy_during_%0d", n), m_busy, 1);
        end
        set_pulse(1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (k < 3 && m_valid) strobes++;
        end
        chk($sformatf("valid_3rd_edge_%0d", n), m_valid, 1);
        chk($sformatf("value_%0d", n), m_value, exp);
        chk($sformatf("ovf_%0d", n), m_ovf, exp_ovf);
        chk($sformatf("early_valid_%0d", n), strobes, 0);
        @(posedge clk);
        #1;
        chk($sformatf("valid_single_%0d", n), m_valid, 0);
        chk($sformatf("busy_after_%0d", n), m_busy, 0);
    endtask

    initial begin
        int strobes, busy_cnt, sat_edge, extra;

        tbl[0] = '{500, 16'd10};
        tbl[1] = '{1000, 16'd20};
        tbl[2] = '{1049, 16'd20};
        tbl[3] = '{1050, 16'd21};
        tbl[4] = '{49, 16'd0};
        tbl[5] = '{1, 16'd0};
        tbl[6] = '{100, 16'd2};
        tbl[7] = '{51, 16'd1};

        // Reset state
        #12;
        chk("rst_value", v50, 0);
        chk("rst_valid", val50, 0);
        chk("rst_ovf", ov50, 0);
        chk("rst_busy", b50, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Enabled with pulse low: nothing happens
        enable = 1'b1;
        watch(20, strobes, busy_cnt);
        chk("idle_strobes", strobes, 0);
        chk("idle_busy", busy_cnt, 0);
        chk("idle_value", v50, 0);

        // Pulse already high when enable rises is not measured
        enable = 1'b0;
        tick_n(3);
        p50 = 1'b1;
        tick_n(10);
        enable = 1'b1;
        watch(100, strobes, busy_cnt);
        p50 = 1'b0;
        watch(10, strobes, extra);
        busy_cnt += extra;
        chk("prehigh_strobes", strobes, 0);
        chk("prehigh_busy", busy_cnt, 0);
        chk("prehigh_value", v50, 0);

        // Table of widths on CLK_DIV=50
        sel = 0;
        for (int i = 0; i < 8; i++) run_pulse(tbl[i].n, tbl[i].exp, 1'b0);

        // Saturation on CLK_DIV=1
        sel = 1;
        tick_n(6);
        p1 = 1'b1;
        sat_edge = 0;
        extra = 0;
        for (int e = 1; e <= 70000; e++) begin
            @(posedge clk);
            #1;
            if (val1) begin
                if (sat_edge == 0) begin
                    sat_edge = e;
                    chk("sat_value", v1, 16'hFFFF);
                    chk("sat_ovf", ov1, 1);
                end else begin
                    extra++;
                end
            end
        end
        p1 = 1'b0;
        watch(10, strobes, busy_cnt);
        extra += strobes;
        chk("sat_edge", sat_edge, 65538);
        chk("sat_no_second", extra, 0);
        chk("sat_busy_after", busy_cnt, 0);
        chk("sat_hold_value", v1, 16'hFFFF);
        chk("sat_hold_ovf", ov1, 1);
        run_pulse(100, 16'd100, 1'b0);

        // Abort by dropping enable mid-pulse
        sel = 0;
        tick_n(6);
        p50 = 1'b1;
        watch(1000, strobes, busy_cnt);
        extra = strobes;
        chk("abort_busy_mid", b50, 1);
        enable = 1'b0;
        watch(5, strobes, busy_cnt);
        extra += strobes;
        chk("abort_busy_off", b50, 0);
        enable = 1'b1;
        watch(995, strobes, busy_cnt);
        extra += strobes;
        chk("abort_rearm_busy", busy_cnt, 0);
        p50 = 1'b0;
        watch(10, strobes, busy_cnt);
        extra += strobes;
        chk("abort_strobes", extra, 0);
        chk("abort_hold_value", v50, 1);

        // Async reset mid-pulse
        tick_n(6);
        p50 = 1'b1;
        tick_n(300);
        chk("rstmid_busy_before", b50, 1);
        reset_n = 1'b0;
        #2;
        chk("rstmid_value", v50, 0);
        chk("rstmid_busy", b50, 0);
        chk("rstmid_value_d1", v1, 0);
        tick_n(2);
        reset_n = 1'b1;
        watch(300, strobes, busy_cnt);
        extra = strobes;
        p50 = 1'b0;
        watch(10, strobes, strobes);
        chk("rstmid_busy_after", busy_cnt, 0);
        chk("rstmid_strobes", extra, 0);
        chk("rstmid_hold_value", v50, 0);
        run_pulse(100, 16'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
